// File: rtl/regbus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : regbus_pkg
// Description : Shared types and constants for the register-bus initiator:
//               FSM state encoding, default bus widths, latency counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package regbus_pkg;

  // Default bus geometry
  localparam int DEF_AW    = 3;
  localparam int DEF_DW    = 2;

  // Width of the read-latency counter (RD_LAT range 0..15)
  localparam int LAT_CNT_W = 4;

  // Initiator FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    RMW_WR = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage : regbus_pkg
`default_nettype wire

// File: rtl/regbus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : regbus_master
// Description : Register-bus initiator. Takes one command at a time from a
//               valid/ready command port, drives WRITE/READ/ADDR/WRITE_DATA,
//               samples the combinational READ_DATA after RD_LAT wait cycles
//               and returns read data on a valid/ready response port.
//               Optional read-modify-write support is compiled in when the
//               macro REGBUS_MASTER_RMW_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module regbus_master
  import regbus_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // command port
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_wr_i,
  input  logic          cmd_rmw_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [DW-1:0] cmd_data_i,
  input  logic [DW-1:0] cmd_mask_i,
  // response port
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_data_o,
  // register bus
  output logic          write_o,
  output logic          read_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] write_data_o,
  input  logic [DW-1:0] read_data_i
);

  // Counter reload value; RD_LAT above 15 is truncated to the counter width
  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LAT);

  state_e                 state_q;
  logic                   cmd_ready_q;
  logic                   rsp_valid_q;
  logic [DW-1:0]          rsp_data_q;
  logic                   write_q;
  logic                   read_q;
  logic [AW-1:0]          addr_q;
  logic [DW-1:0]          wdata_q;
  logic [LAT_CNT_W-1:0]   cnt_q;
  logic                   w_is_read;

`ifdef REGBUS_MASTER_RMW_EN
  logic                   rmw_q;
  logic [DW-1:0]          data_q;
  logic [DW-1:0]          mask_q;
  logic [DW-1:0]          rdata_q;
  logic [DW-1:0]          w_merge;

  // RMW takes precedence over the write flag and always starts with a read
  assign w_is_read = cmd_rmw_i | ~cmd_wr_i;
  // New value: masked bits from the command, the rest from the old value
  assign w_merge   = (read_data_i & ~mask_q) | (data_q & mask_q);
`else
  logic                   unused_rmw;

  assign w_is_read  = ~cmd_wr_i;
  // RMW inputs are kept on the port list but have no function in this build
  assign unused_rmw = ^{cmd_rmw_i, cmd_mask_i};
`endif

  // Command sequencer: all bus and handshake outputs are registered here
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
`ifdef REGBUS_MASTER_RMW_EN
      rmw_q       <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
      rdata_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr_i;
            cnt_q       <= LAT_INIT;
`ifdef REGBUS_MASTER_RMW_EN
            rmw_q       <= cmd_rmw_i;
            data_q      <= cmd_data_i;
            mask_q      <= cmd_mask_i;
`endif
            if (w_is_read) begin
              read_q  <= 1'b1;
              state_q <= RD;
            end else begin
              write_q <= 1'b1;
              wdata_q <= cmd_data_i;
              state_q <= WR;
            end
          end else begin
            // First IDLE cycle after reset raises ready
            cmd_ready_q <= 1'b1;
          end
        end

        WR: begin
          write_q     <= 1'b0;
          addr_q      <= '0;
          wdata_q     <= '0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end

        RD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - LAT_CNT_W'(1);
          end else begin
            read_q      <= 1'b0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= read_data_i;
            state_q     <= RESP;
`ifdef REGBUS_MASTER_RMW_EN
            // RMW goes on to the write phase instead of responding now
            if (rmw_q) begin
              addr_q      <= addr_q;
              rsp_valid_q <= 1'b0;
              rsp_data_q  <= rsp_data_q;
              rdata_q     <= read_data_i;
              write_q     <= 1'b1;
              wdata_q     <= w_merge;
              state_q     <= RMW_WR;
            end
`endif
          end
        end

`ifdef REGBUS_MASTER_RMW_EN
        RMW_WR: begin
          write_q     <= 1'b0;
          addr_q      <= '0;
          wdata_q     <= '0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= rdata_q;
          state_q     <= RESP;
        end
`endif

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          cmd_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          write_q     <= 1'b0;
          read_q      <= 1'b0;
          addr_q      <= '0;
          wdata_q     <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign write_o      = write_q;
  assign read_o       = read_q;
  assign addr_o       = addr_q;
  assign write_data_o = wdata_q;

endmodule : regbus_master
`default_nettype wire

// File: tb/tb_regbus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_regbus_master
// Description : Self-checking bench for regbus_master. One instance with
//               RD_LAT=0 talks to a register-map slave model; a second with
//               RD_LAT=3 is fed a hand-driven READ_DATA.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regbus_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_wr = 1'b0;
  logic       cmd_rmw = 1'b0;
  logic [2:0] cmd_addr = '0;
  logic [1:0] cmd_data = '0;
  logic [1:0] cmd_mask = '0;
  logic       rsp_ready = 1'b1;

  logic       cmd_valid0 = 1'b0;
  logic       cmd_ready0, rsp_valid0, write0, read0;
  logic [1:0] rsp_data0, wdata0, rdata0;
  logic [2:0] addr0;

  logic       cmd_valid3 = 1'b0;
  logic       cmd_ready3, rsp_valid3, write3, read3;
  logic [1:0] rsp_data3, wdata3;
  logic [1:0] ovr3 = 2'b00;
  logic [2:0] addr3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regbus_master #(.AW(3), .DW(2), .RD_LAT(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid0), .cmd_ready_o(cmd_ready0),
    .cmd_wr_i(cmd_wr), .cmd_rmw_i(cmd_rmw), .cmd_addr_i(cmd_addr),
    .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data0),
    .write_o(write0), .read_o(read0), .addr_o(addr0),
    .write_data_o(wdata0), .read_data_i(rdata0)
  );

  regbus_master #(.AW(3), .DW(2), .RD_LAT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid3), .cmd_ready_o(cmd_ready3),
    .cmd_wr_i(cmd_wr), .cmd_rmw_i(cmd_rmw), .cmd_addr_i(cmd_addr),
    .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data3),
    .write_o(write3), .read_o(read3), .addr_o(addr3),
    .write_data_o(wdata3), .read_data_i(ovr3)
  );

  // Register-map slave behind dut0: eight 2-bit registers, combinational read
  logic [1:0] mem0 [8];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem0[i] <= 2'b00;
    end else if (write0) begin
      mem0[addr0] <= wdata0;
    end
  end
  assign rdata0 = mem0[addr0];

  typedef struct {
    logic       wr;
    logic       rmw;
    logic [2:0] addr;
    logic [1:0] data;
    logic [1:0] mask;
    logic       exp_wr;
    logic [1:0] exp_wdata;
    logic       exp_rd;
    logic [1:0] exp_rsp;
    int         exp_cyc;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready0(input string name);
    int n = 0;
    while (!cmd_ready0 && n < 20) begin tick(); n++; end
    check({name, " ready0"}, {31'd0, cmd_ready0}, 32'd1);
  endtask

  task automatic wait_ready3(input string name);
    int n = 0;
    while (!cmd_ready3 && n < 20) begin tick(); n++; end
    check({name, " ready3"}, {31'd0, cmd_ready3}, 32'd1);
  endtask

  // One command through dut0 with RSP_READY high; observe until ready returns
  task automatic run_vec(input vec_t v, input int idx);
    int k, nwr, nrd;
    logic both, rsp_seen;
    logic [1:0] wd_seen, rsp_d;
    logic [2:0] a_wr, a_rd;
    string tag;
    tag = $sformatf("vec%0d", idx);
    wait_ready0(tag);
    cmd_wr = v.wr; cmd_rmw = v.rmw; cmd_addr = v.addr;
    cmd_data = v.data; cmd_mask = v.mask;
    cmd_valid0 = 1'b1;
    tick();
    cmd_valid0 = 1'b0;
    k = 1; nwr = 0; nrd = 0; both = 1'b0; rsp_seen = 1'b0;
    wd_seen = '0; rsp_d = '0; a_wr = '0; a_rd = '0;
    forever begin
      if (write0) begin nwr++; wd_seen = wdata0; a_wr = addr0; end
      if (read0)  begin nrd++; a_rd = addr0; end
      if (write0 && read0) both = 1'b1;
      if (rsp_valid0) begin rsp_seen = 1'b1; rsp_d = rsp_data0; end
      if (cmd_ready0 || k >= 20) break;
      tick();
      k++;
    end
    check({tag, " cycles"}, k, v.exp_cyc);
    check({tag, " writes"}, nwr, {31'd0, v.exp_wr});
    check({tag, " reads"}, nrd, {31'd0, v.exp_rd});
    check({tag, " rsp seen"}, {31'd0, rsp_seen}, {31'd0, v.exp_rd});
    check({tag, " rd+wr overlap"}, {31'd0, both}, 32'd0);
    if (v.exp_wr) begin
      check({tag, " wdata"}, {30'd0, wd_seen}, {30'd0, v.exp_wdata});
      check({tag, " wr addr"}, {29'd0, a_wr}, {29'd0, v.addr});
    end
    if (v.exp_rd) begin
      check({tag, " rsp data"}, {30'd0, rsp_d}, {30'd0, v.exp_rsp});
      check({tag, " rd addr"}, {29'd0, a_rd}, {29'd0, v.addr});
    end
  endtask

  initial begin
    vec_t vb;
    logic [1:0] hold_d;
    int k, nrd;

    //           wr    rmw   addr  data   mask   e_wr  e_wdat e_rd  e_rsp  cyc
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 2'b10, 2'b00, 1'b1, 2'b10, 1'b0, 2'b00, 2};
    vecs[1]  = '{1'b0, 1'b0, 3'd0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b10, 3};
    vecs[2]  = '{1'b1, 1'b0, 3'd5, 2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 2};
    vecs[3]  = '{1'b0, 1'b0, 3'd5, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b01, 3};
    vecs[4]  = '{1'b0, 1'b0, 3'd3, 2'b11, 2'b11, 1'b0, 2'b00, 1'b1, 2'b00, 3};
    vecs[5]  = '{1'b1, 1'b0, 3'd7, 2'b11, 2'b00, 1'b1, 2'b11, 1'b0, 2'b00, 2};
    vecs[6]  = '{1'b0, 1'b0, 3'd7, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b11, 3};
`ifdef REGBUS_MASTER_RMW_EN
    // old 01, data 10, mask 10 -> new 11, response carries old value
    vecs[7]  = '{1'b1, 1'b1, 3'd5, 2'b10, 2'b10, 1'b1, 2'b11, 1'b1, 2'b01, 4};
    vecs[8]  = '{1'b0, 1'b0, 3'd5, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b11, 3};
    // old 11, data 00, mask 01 -> new 10
    vecs[9]  = '{1'b0, 1'b1, 3'd7, 2'b00, 2'b01, 1'b1, 2'b10, 1'b1, 2'b11, 4};
    vecs[10] = '{1'b0, 1'b0, 3'd7, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b10, 3};
`else
    // RMW ignored: plain write of 10, then plain read of reg7
    vecs[7]  = '{1'b1, 1'b1, 3'd5, 2'b10, 2'b10, 1'b1, 2'b10, 1'b0, 2'b00, 2};
    vecs[8]  = '{1'b0, 1'b0, 3'd5, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b10, 3};
    vecs[9]  = '{1'b0, 1'b1, 3'd7, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 2'b11, 3};
    vecs[10] = '{1'b0, 1'b0, 3'd7, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b11, 3};
`endif

    // ---- reset state ----
    #1 rst_n = 1'b0;
    #1;
    check("rst cmd_ready", {31'd0, cmd_ready0}, 32'd0);
    check("rst rsp_valid", {31'd0, rsp_valid0}, 32'd0);
    check("rst strobes", {30'd0, write0, read0}, 32'd0);
    check("rst addr/wdata/rsp", {25'd0, addr0, wdata0, rsp_data0}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post-rst cmd_ready", {31'd0, cmd_ready0}, 32'd1);

    // ---- table-driven commands ----
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // ---- back-to-back writes: WRITE = 1, 0, 1 ----
    wait_ready0("b2b");
    cmd_wr = 1'b1; cmd_rmw = 1'b0; cmd_addr = 3'd1; cmd_data = 2'b01; cmd_mask = 2'b00;
    cmd_valid0 = 1'b1;
    tick();
    check("b2b w1", {26'd0, write0, read0, addr0, wdata0} , {26'd0, 1'b1, 1'b0, 3'd1, 2'b01});
    cmd_addr = 3'd2; cmd_data = 2'b10;
    tick();
    check("b2b gap", {26'd0, write0, read0, addr0, wdata0}, 32'd0);
    tick();
    check("b2b w2", {26'd0, write0, read0, addr0, wdata0}, {26'd0, 1'b1, 1'b0, 3'd2, 2'b10});
    cmd_valid0 = 1'b0;
    tick();

    // ---- response backpressure: read reg0 (holds 10), RSP_READY low ----
    rsp_ready = 1'b0;
    wait_ready0("bp");
    cmd_wr = 1'b0; cmd_rmw = 1'b0; cmd_addr = 3'd0;
    cmd_valid0 = 1'b1;
    tick();
    cmd_valid0 = 1'b0;
    tick();
    check("bp valid entry", {31'd0, rsp_valid0}, 32'd1);
    hold_d = rsp_data0;
    check("bp data entry", {30'd0, hold_d}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        cmd_wr = 1'b1; cmd_addr = 3'd6; cmd_data = 2'b11;
        cmd_valid0 = 1'b1;
      end
      tick();
      cmd_valid0 = 1'b0;
      check($sformatf("bp hold%0d", i),
            {27'd0, rsp_valid0, rsp_data0, cmd_ready0, write0},
            {27'd0, 1'b1, hold_d, 1'b0, 1'b0});
    end
    rsp_ready = 1'b1;
    tick();
    check("bp release valid", {31'd0, rsp_valid0}, 32'd0);
    check("bp release ready", {31'd0, cmd_ready0}, 32'd1);
    // the pulsed write to reg6 must not have happened
    vb = '{1'b0, 1'b0, 3'd6, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 3};
    run_vec(vb, 99);

    // ---- RD_LAT=3: READ held 4 cycles, value at the 4th edge returned ----
    wait_ready3("lat3");
    cmd_wr = 1'b0; cmd_rmw = 1'b0; cmd_addr = 3'd4;
    ovr3 = 2'b01;
    cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    k = 1; nrd = 0;
    check("lat3 addr", {29'd0, addr3}, 32'd4);
    forever begin
      if (read3) nrd++;
      case (k)
        1: ovr3 = 2'b01;
        2: ovr3 = 2'b10;
        3: ovr3 = 2'b00;
        4: ovr3 = 2'b11;
        default: ovr3 = 2'b00;
      endcase
      if (rsp_valid3 || k >= 15) break;
      tick();
      k++;
    end
    check("lat3 read cycles", nrd, 32'd4);
    check("lat3 rsp cycle", k, 32'd5);
    check("lat3 rsp data", {30'd0, rsp_data3}, 32'd3);
    tick();

    // ---- reset in the middle of a long read ----
    wait_ready3("rstmid");
    cmd_addr = 3'd5; ovr3 = 2'b10;
    cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    tick();
    check("rstmid read before", {31'd0, read3}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid async", {26'd0, read3, rsp_valid3, addr3, cmd_ready3}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rstmid no rsp%0d", i), {30'd0, rsp_valid3, read3}, 32'd0);
    end
    check("rstmid ready", {31'd0, cmd_ready3}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_regbus_master
`default_nettype wire
